// File: rtl/soc_system_st_ready_latency_expander.sv
// Avalon-ST ready-latency adapter: readyLatency=IN_RL sink to readyLatency=0 source.
// Credit-counted show-ahead FIFO absorbs beats still in flight when the consumer stalls.
module soc_system_st_ready_latency_expander #(
   parameter int DATA_W = 24,
   parameter int IN_RL  = 1,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              in_ready,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_startofpacket,
   input  logic              in_endofpacket,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_startofpacket,
   output logic              out_endofpacket,
   output logic              overflow
);

   localparam int CW  = $clog2(DEPTH + 1);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PLW = DATA_W + 2;
   localparam int SW  = CW + 2;

   logic [PLW-1:0]   mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [IN_RL-1:0] hist_q, hist_d;
   logic             run_q;
   logic             ovf_q, ovf_d;
   logic             full, push, pop;
   logic [SW-1:0]    credit_sum;

   // Outstanding grants are counted as already occupied; pops are ignored so
   // in_ready stays a function of registers only.
   always_comb begin
      credit_sum = {2'b00, count_q} + SW'(1);
      for (int i = 0; i < IN_RL; i++) begin
         credit_sum = credit_sum + SW'(hist_q[i]);
      end
   end

   assign in_ready  = run_q && (credit_sum <= SW'(DEPTH));
   assign full      = (count_q == CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign push      = in_valid && (!full || pop);

   assign {out_data, out_startofpacket, out_endofpacket} = mem_q[rd_ptr_q];
   assign overflow = ovf_q;

   if (IN_RL == 1) begin : g_hist1
      assign hist_d = in_ready;
   end else begin : g_histn
      assign hist_d = {hist_q[IN_RL-2:0], in_ready};
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
      ovf_d   = ovf_q | (in_valid && full && !pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hist_q   <= '0;
         run_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hist_q   <= hist_d;
         run_q    <= 1'b1;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= {in_data, in_startofpacket, in_endofpacket};
      end
   end

endmodule
